// File: rtl/data_memory_be.sv
// Byte-enabled RV32I data memory with a clear-then-preload reset sequencer.
// Latency: loads are combinational; stores commit on the rising edge.
// Backpressure: busy holds the core off until the reset sequence completes; stores seen while busy are dropped.
module data_memory_be #(
    parameter int          ADDR_W         = 16,
    parameter logic [31:0] INIT_ADDR      = 32'h0000_8000,
    parameter logic [31:0] INIT_VAL       = 32'd10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        WE,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        busy,
    output logic        misaligned
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] INIT_IDX = INIT_ADDR[ADDR_W+1:2];

    // READY encodes as zero so a zero-initialised simulation starts usable.
    typedef enum logic [1:0] {
        S_READY   = 2'd0,
        S_CLEAR   = 2'd1,
        S_PRELOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       mem_q [0:DEPTH-1];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rword;
    logic [31:0]       rshift;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              mis_raw;
    logic              ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wdat;
    logic [3:0]        mem_be;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^A[31:ADDR_W+2];

    assign word_idx = A[ADDR_W+1:2];
    assign lane     = A[1:0];
    assign rword    = mem_q[word_idx];
    assign rshift   = rword >> {lane, 3'b000};
    assign byte_v   = rshift[7:0];
    assign half_v   = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        mis_raw = 1'b0;
        case (funct3)
            3'b001, 3'b101: mis_raw = A[0];
            3'b010:         mis_raw = (A[1:0] != 2'b00);
            default:        mis_raw = 1'b0;
        endcase
    end

    assign ready      = (state_q == S_READY) && !rst;
    assign busy       = !ready;
    assign misaligned = ready && mis_raw;

    always_comb begin
        RD = 32'd0;
        if (ready && !mis_raw) begin
            case (funct3)
                3'b000:  RD = {{24{byte_v[7]}}, byte_v};
                3'b001:  RD = {{16{half_v[15]}}, half_v};
                3'b010:  RD = rword;
                3'b100:  RD = {24'd0, byte_v};
                3'b101:  RD = {16'd0, half_v};
                default: RD = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_idx  = word_idx;
        mem_wdat = 32'd0;
        mem_be   = 4'b0000;
        if (rst) begin
            state_d = CLEAR_ON_RESET ? S_CLEAR : S_PRELOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    mem_we  = 1'b1;
                    mem_idx = cnt_q;
                    mem_be  = 4'b1111;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_d = S_PRELOAD;
                    end
                end
                S_PRELOAD: begin
                    mem_we   = 1'b1;
                    mem_idx  = INIT_IDX;
                    mem_be   = 4'b1111;
                    mem_wdat = INIT_VAL;
                    state_d  = S_READY;
                end
                S_READY: begin
                    // Sub-word data is replicated across lanes; the byte mask picks the target.
                    if (WE && !mis_raw) begin
                        case (funct3)
                            3'b000: begin
                                mem_we   = 1'b1;
                                mem_be   = 4'b0001 << lane;
                                mem_wdat = {4{WD[7:0]}};
                            end
                            3'b001: begin
                                mem_we   = 1'b1;
                                mem_be   = lane[1] ? 4'b1100 : 4'b0011;
                                mem_wdat = {2{WD[15:0]}};
                            end
                            3'b010: begin
                                mem_we   = 1'b1;
                                mem_be   = 4'b1111;
                                mem_wdat = WD;
                            end
                            default: mem_we = 1'b0;
                        endcase
                    end
                end
                default: state_d = S_READY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= mem_wdat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be (16 words, preload at word 8) against a byte-array model.
module tb_data_memory_be;

    logic        CLK;
    logic        rst;
    logic        WE;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        busy;
    logic        misaligned;

    logic [7:0]  rm [0:63];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_edges;

    data_memory_be #(
        .ADDR_W    (4),
        .INIT_ADDR (32'h0000_0020)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .WE         (WE),
        .funct3     (funct3),
        .A          (A),
        .WD         (WD),
        .RD         (RD),
        .busy       (busy),
        .misaligned (misaligned)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_mis(input logic [2:0] f, input logic [31:0] a);
        return ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'd0);
    endfunction

    // Memory is 64 bytes, little-endian; higher address bits alias.
    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
        int          base;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        base = int'(a[5:0]);
        if (ref_mis(f, a)) return 32'd0;
        b = rm[base];
        h = {rm[base | 1], rm[base & ~1]};
        w = {rm[(base & 60) + 3], rm[(base & 60) + 2], rm[(base & 60) + 1], rm[base & 60]};
        case (f)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd2:    return w;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int base;
        base = int'(a[5:0]);
        if (ref_mis(f, a)) return;
        case (f)
            3'd0: rm[base] = d[7:0];
            3'd1: begin
                rm[base]     = d[7:0];
                rm[base + 1] = d[15:8];
            end
            3'd2: for (int i = 0; i < 4; i++) rm[base + i] = d[8*i +: 8];
            default: ;
        endcase
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 64; i++) rm[i] = 8'd0;
        rm[32] = 8'd10;
    endtask

    task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        WE = 1'b1; funct3 = f; A = a; WD = d;
        #1;
        check("store_misaligned", 32'(misaligned), 32'(ref_mis(f, a)));
        @(posedge CLK);
        ref_store(f, a, d);
        #1;
        WE = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] exp);
        WE = 1'b0; funct3 = f; A = a;
        #1;
        check(tag, RD, exp);
        @(posedge CLK);
        #1;
    endtask

    // Counts edges until busy drops; optionally checks the gated outputs while busy.
    task automatic run_seq(input bit chk_outputs, output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
            if (busy && chk_outputs) begin
                check("busy_rd_zero", RD, 32'd0);
                check("busy_mis_zero", 32'(misaligned), 32'd0);
            end
        end while (busy && n < 100);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rd_val;
        logic        rwe;

        rst = 1'b1; WE = 1'b0; funct3 = 3'd1; A = 32'd1; WD = 32'd0;
        ref_reset();

        // Reset: two edges with rst high, then time the sequence.
        @(posedge CLK); #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rd", RD, 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0;
        run_seq(1'b0, n_edges);
        check("reset_edges", 32'(n_edges), 32'd17);
        do_load("lw_preload", 3'd2, 32'h20, 32'd10);
        do_load("lw_after_preload", 3'd2, 32'h24, 32'd0);

        // Byte and halfword stores.
        do_store(3'd2, 32'h04, 32'h1122_3344);
        do_store(3'd0, 32'h05, 32'h0000_00AA);
        do_store(3'd1, 32'h06, 32'h0000_BEEF);
        do_load("lw_merged", 3'd2, 32'h04, 32'hBEEF_AA44);
        do_load("lb_sign", 3'd0, 32'h05, 32'hFFFF_FFAA);
        do_load("lbu_zero", 3'd4, 32'h05, 32'h0000_00AA);
        do_load("lh_sign", 3'd1, 32'h06, 32'hFFFF_BEEF);
        do_load("lhu_zero", 3'd5, 32'h06, 32'h0000_BEEF);

        // Misaligned stores are suppressed.
        do_store(3'd2, 32'h09, 32'h1234_5678);
        do_store(3'd1, 32'h0B, 32'h0000_BEEF);
        do_load("lw_word2_untouched", 3'd2, 32'h08, 32'd0);
        funct3 = 3'd1; A = 32'h01; #1;
        check("lh_mis_rd", RD, 32'd0);
        check("lh_mis_flag", 32'(misaligned), 32'd1);
        @(posedge CLK); #1;

        // Address aliasing.
        do_store(3'd2, 32'h40, 32'hCAFE_F00D);
        do_load("lw_alias_0", 3'd2, 32'h00, 32'hCAFE_F00D);
        do_load("lw_alias_high", 3'd2, 32'h1000_0000, 32'hCAFE_F00D);

        // Randomised accesses against the model.
        repeat (300) begin
            rf     = 3'($urandom_range(0, 7));
            ra     = $urandom;
            rd_val = $urandom;
            rwe    = 1'($urandom_range(0, 1));
            WE = rwe; funct3 = rf; A = ra; WD = rd_val;
            #1;
            check("rand_rd", RD, ref_load(rf, ra));
            check("rand_mis", 32'(misaligned), 32'(ref_mis(rf, ra)));
            @(posedge CLK);
            if (rwe) ref_store(rf, ra, rd_val);
            #1;
            WE = 1'b0;
        end

        // Reset restarted mid-clear.
        for (int i = 0; i < 16; i++) do_store(3'd2, 32'(i * 4), 32'hA500_0000 | 32'(i + 1));
        do_load("lw_filled_w5", 3'd2, 32'h14, 32'hA500_0006);
        rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("midclear_busy", 32'(busy), 32'd1);
        end
        rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0;
        run_seq(1'b0, n_edges);
        check("midclear_edges", 32'(n_edges), 32'd17);
        ref_reset();
        for (int i = 0; i < 16; i++) do_load("lw_after_clear", 3'd2, 32'(i * 4), ref_load(3'd2, 32'(i * 4)));
        do_load("lw_preload_again", 3'd2, 32'h20, 32'd10);

        // Stores held across the whole reset sequence are dropped.
        do_store(3'd2, 32'h0C, 32'h0000_0055);
        WE = 1'b1; funct3 = 3'd2; A = 32'h0C; WD = 32'hFFFF_FFFF;
        rst = 1'b1;
        #1;
        check("busy_rst_rd", RD, 32'd0);
        check("busy_rst_flag", 32'(busy), 32'd1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst = 1'b0;
        run_seq(1'b1, n_edges);
        WE = 1'b0;
        check("busy_store_edges", 32'(n_edges), 32'd17);
        ref_reset();
        do_load("lw_word3_dropped", 3'd2, 32'h0C, 32'd0);
        do_load("lw_preload_final", 3'd2, 32'h20, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
